// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line levels and default framing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  localparam int unsigned UART_DATA_BITS     = 8;
  localparam int unsigned UART_STOP_BITS     = 1;
  localparam int unsigned UART_MAX_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_if.sv
// AXI-Stream byte channel feeding the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_MAX_DATA_BITS-1:0] tdata;
  logic                          tvalid;
  logic                          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter; tick_c pulses for one cycle at zero, then reloads.
module uart_baud_tick #(
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      en_i,
  input  logic                      load_i,
  input  logic [PRESCALE_WIDTH-1:0] load_val_i,
  input  logic [PRESCALE_WIDTH-1:0] reload_val_i,
  output logic                      tick_c
);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

  assign tick_c = en_i && !load_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (cnt_q == '0) cnt_d = reload_val_i;
      else             cnt_d = cnt_q - PRESCALE_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// AXI-Stream to serial UART transmitter, LSB first, runtime prescaler.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS      = UART_DATA_BITS,
  parameter int unsigned STOP_BITS      = UART_STOP_BITS,
  parameter int unsigned PRESCALE_WIDTH = 16,
  parameter int unsigned PARITY_ODD     = 0
) (
  input  logic                      aclk,
  input  logic                      areset,
  uart_tx_if.slave                  s_axis,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      txd,
  output logic                      busy
);

  localparam int unsigned BIT_CNT_W = $clog2(UART_MAX_DATA_BITS);

  uart_state_e               state_q, state_d;
  logic [DATA_BITS-1:0]      shift_q, shift_d;
  logic [PRESCALE_WIDTH-1:0] period_q, period_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic                      txd_q, txd_d;
  logic                      tready_q, tready_d;
  logic                      busy_q, busy_d;
  logic                      load_c;
  logic                      tick_c;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  assign s_axis.tready = tready_q;
  assign txd           = txd_q;
  assign busy          = busy_q;

  uart_baud_tick #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_baud_tick (
    .aclk         (aclk),
    .areset       (areset),
    .en_i         (state_q != ST_IDLE),
    .load_i       (load_c),
    .load_val_i   (prescale),
    .reload_val_i (period_q),
    .tick_c       (tick_c)
  );

  // Next-state, datapath and pin level, all decided one cycle ahead of the registers.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    period_d   = period_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    load_c     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (s_axis.tvalid && tready_q) begin
          state_d    = ST_START;
          shift_d    = s_axis.tdata[DATA_BITS-1:0];
          period_d   = prescale;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          load_c     = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d   = (^s_axis.tdata[DATA_BITS-1:0]) ^ 1'(PARITY_ODD);
`endif
        end
      end
      ST_START: begin
        if (tick_c) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick_c) begin
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_c) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick_c) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            state_d    = ST_IDLE;
            stop_cnt_d = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  txd_d = UART_START_LEVEL;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = UART_IDLE_LEVEL;
    endcase

    tready_d = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      period_q   <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= UART_IDLE_LEVEL;
      tready_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      period_q   <= period_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      tready_q   <= tready_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: 8N1/even-parity instance and 8N2/odd-parity instance vs a frame-level model.
module tb_uart_tx;

  localparam int unsigned PW = 16;

  logic          aclk;
  logic          areset;
  logic [7:0]    tdata;
  logic          tvalid;
  logic [PW-1:0] prescale;
  logic          sel;
  logic          txd1, busy1, txd2, busy2;
  logic          obs_txd, obs_busy, obs_tready;

  int tests  = 0;
  int failed = 0;
  bit exp_q[$];

  uart_tx_if if1 ();
  uart_tx_if if2 ();

  assign if1.tdata  = tdata;
  assign if2.tdata  = tdata;
  assign if1.tvalid = tvalid & ~sel;
  assign if2.tvalid = tvalid & sel;

  assign obs_txd    = sel ? txd2 : txd1;
  assign obs_busy   = sel ? busy2 : busy1;
  assign obs_tready = sel ? if2.tready : if1.tready;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PRESCALE_WIDTH(PW), .PARITY_ODD(0)) dut1 (
    .aclk(aclk), .areset(areset), .s_axis(if1), .prescale(prescale), .txd(txd1), .busy(busy1)
  );

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PRESCALE_WIDTH(PW), .PARITY_ODD(1)) dut2 (
    .aclk(aclk), .areset(areset), .s_axis(if2), .prescale(prescale), .txd(txd2), .busy(busy2)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame as a list of line levels: start, data LSB first, optional parity, stop bits.
  function automatic void build_frame(input logic [7:0] d, input bit s);
    int sb;
    sb = s ? 2 : 1;
    exp_q = {};
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back((^d) ^ s);
`endif
    for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
  endfunction

  // Call at a negedge. Waits for tready, handshakes, then checks every frame cycle.
  task automatic send_frame(input bit s, input logic [7:0] d, input int p, input bit b2b,
                            input logic [7:0] nxt, input int abort_at, input bit chk_gap);
    int wait_n;
    int f;
    sel      = s;
    tdata    = d;
    prescale = PW'(p);
    tvalid   = 1'b1;
    wait_n   = 0;
    while (!obs_tready && wait_n < 64) begin
      @(negedge aclk);
      wait_n++;
    end
    if (!obs_tready) begin
      check("hs_timeout", 32'(obs_tready), 32'd1);
      tvalid = 1'b0;
      return;
    end
    if (chk_gap) check("b2b_gap", 32'(wait_n), 32'd0);
    @(posedge aclk);
    #1;
    tvalid   = b2b;
    tdata    = nxt;
    prescale = PW'($urandom);
    build_frame(d, s);
    f = 0;
    foreach (exp_q[i]) begin
      for (int k = 0; k <= p; k++) begin
        if (f == abort_at) return;
        @(negedge aclk);
        check($sformatf("txd_b%0d_c%0d", i, k), 32'(obs_txd), 32'(exp_q[i]));
        check("busy_frame", 32'(obs_busy), 32'd1);
        check("tready_frame", 32'(obs_tready), 32'd0);
        f++;
      end
    end
    @(negedge aclk);
    check("txd_idle", 32'(obs_txd), 32'd1);
    check("busy_idle", 32'(obs_busy), 32'd0);
    check("tready_idle", 32'(obs_tready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd, rnd;
    int         rp;
    bit         rb, rsel, gap;

    areset   = 1'b1;
    tvalid   = 1'b0;
    tdata    = 8'h00;
    prescale = '0;
    sel      = 1'b0;

    repeat (5) begin
      @(negedge aclk);
      check("rst_txd1", 32'(txd1), 32'd1);
      check("rst_txd2", 32'(txd2), 32'd1);
      check("rst_tready1", 32'(if1.tready), 32'd0);
      check("rst_busy1", 32'(busy1), 32'd0);
      check("rst_busy2", 32'(busy2), 32'd0);
    end
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_tready", 32'(if1.tready), 32'd1);
    check("post_rst_txd", 32'(txd1), 32'd1);

    send_frame(1'b0, 8'h55, 3, 1'b0, 8'h00, -1, 1'b0);

    send_frame(1'b0, 8'hA3, 1, 1'b1, 8'h0F, -1, 1'b0);
    send_frame(1'b0, 8'h0F, 1, 1'b0, 8'h00, -1, 1'b1);

    send_frame(1'b1, 8'hFF, 0, 1'b0, 8'h00, -1, 1'b0);

    send_frame(1'b0, 8'h07, 0, 1'b0, 8'h00, -1, 1'b0);
    send_frame(1'b1, 8'h07, 0, 1'b0, 8'h00, -1, 1'b0);

    // Abort 0xC3 two cycles into data bit 3 with an asynchronous reset.
    send_frame(1'b0, 8'hC3, 3, 1'b0, 8'h00, 18, 1'b0);
    #2;
    areset = 1'b1;
    #1;
    check("async_rst_txd", 32'(txd1), 32'd1);
    check("async_rst_busy", 32'(busy1), 32'd0);
    check("async_rst_tready", 32'(if1.tready), 32'd0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("rel_tready", 32'(if1.tready), 32'd1);
    repeat (10) begin
      @(negedge aclk);
      check("no_residual_txd", 32'(txd1), 32'd1);
      check("no_residual_busy", 32'(busy1), 32'd0);
    end
    send_frame(1'b0, 8'h3C, 3, 1'b0, 8'h00, -1, 1'b0);

    rsel = 1'($urandom_range(0, 1));
    rd   = 8'($urandom);
    gap  = 1'b0;
    for (int n = 0; n < 24; n++) begin
      rp  = int'($urandom_range(0, 3));
      rb  = (n < 23) && ($urandom_range(0, 1) == 1);
      rnd = 8'($urandom);
      send_frame(rsel, rd, rp, rb, rnd, -1, gap);
      gap = rb;
      rd  = rnd;
      if (!rb) rsel = 1'($urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
